// File: rtl/servo_motion_sequencer.sv
// Slew-limited PWM frame sequencer for five hobby servos.
// A microsecond frame timer drives five per-servo PWM lanes. Near the end of
// each frame a short CALC phase walks one shared angle-to-width datapath
// across the servos. It moves each current angle toward its target by at most
// STEP degrees and stages the resulting pulse widths for the next frame.

module servo_pwm_lane #(
  parameter int FW = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [11:0]   next_w,
  input  logic [FW-1:0] frame_cnt_nxt,
  output logic          pwm
);
  logic [11:0] active_w;
  logic [11:0] active_w_nxt;

  // The staged width takes over exactly on the frame wrap, so a pulse never changes mid-frame
  always_comb begin
    active_w_nxt = load ? next_w : active_w;
  end

  // The compare uses the post-update counter and width so the output edge lands on the boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      active_w <= 12'd1490;
      pwm      <= 1'b0;
    end else begin
      active_w <= active_w_nxt;
      pwm      <= frame_cnt_nxt < FW'(active_w_nxt);
    end
  end
endmodule

module servo_motion_sequencer #(
  parameter int CLK_PER_US = 50,
  parameter int FRAME_US   = 20000,
  parameter int STEP       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_servo,
  input  logic [7:0] cmd_angle,
  output logic       cmd_err,
  output logic       busy,
  output logic       frame_start,
  output logic [4:0] pwm_out
);
  localparam int NUM_SERVO = 5;
  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int FW = $clog2(FRAME_US);
  localparam logic signed [8:0] STEP_S = 9'(STEP);

  typedef enum logic {RUN = 1'b0, CALC = 1'b1} state_t;

  state_t                          state, state_nxt;
  logic [PW-1:0]                   prescaler;
  logic [FW-1:0]                   frame_cnt, frame_cnt_nxt;
  logic                            us_tick, wrap, calc_go, accept;
  logic [2:0]                      calc_idx;
  logic [NUM_SERVO-1:0][7:0]       cur, tgt;
  logic [NUM_SERVO-1:0][11:0]      next_w;
  logic [7:0]                      sel_cur, sel_tgt, new_cur, clamp_angle;
  logic signed [8:0]               diff;
  logic [11:0]                     new_w;

  // Timer decode: the CALC phase is launched one microsecond before the wrap
  always_comb begin
    us_tick       = (prescaler == PW'(CLK_PER_US - 1));
    wrap          = us_tick && (frame_cnt == FW'(FRAME_US - 1));
    calc_go       = us_tick && (frame_cnt == FW'(FRAME_US - 2));
    frame_cnt_nxt = wrap ? '0 : (us_tick ? frame_cnt + 1'b1 : frame_cnt);
  end

  // Prescaler and frame counter run freely in every state
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler   <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      prescaler   <= us_tick ? '0 : prescaler + 1'b1;
      frame_cnt   <= frame_cnt_nxt;
      frame_start <= wrap;
    end
  end

  // State register and the CALC servo index
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      calc_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == RUN && calc_go) calc_idx <= '0;
      else if (state == CALC)      calc_idx <= calc_idx + 1'b1;
    end
  end

  // Next state and command readiness; commands are held off while CALC owns the datapath
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    case (state)
      RUN: begin
        cmd_ready = !rst;
        if (calc_go) state_nxt = CALC;
      end
      CALC: begin
        if (calc_idx == 3'd4) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Shared slew-limit and angle-to-width datapath, selected by calc_idx
  always_comb begin
    sel_cur     = cur[calc_idx];
    sel_tgt     = tgt[calc_idx];
    diff        = $signed({1'b0, sel_tgt}) - $signed({1'b0, sel_cur});
    if (diff > STEP_S)       new_cur = sel_cur + 8'(STEP);
    else if (diff < -STEP_S) new_cur = sel_cur - 8'(STEP);
    else                     new_cur = sel_tgt;
    new_w       = 12'(new_cur) * 12'd11 + 12'd500;
    accept      = cmd_valid && cmd_ready;
    clamp_angle = (cmd_angle > 8'd180) ? 8'd180 : cmd_angle;
  end

  // Target writes from the command port and per-servo updates during CALC
  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= {NUM_SERVO{8'd90}};
      tgt     <= {NUM_SERVO{8'd90}};
      next_w  <= {NUM_SERVO{12'd1490}};
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= accept && (cmd_servo >= 3'd5);
      if (accept && cmd_servo < 3'd5) tgt[cmd_servo] <= clamp_angle;
      if (state == CALC) begin
        cur[calc_idx]    <= new_cur;
        next_w[calc_idx] <= new_w;
      end
    end
  end

  // Packed inequality is the OR of per-servo mismatches
  always_ff @(posedge clk) begin
    if (rst) busy <= 1'b0;
    else     busy <= (cur != tgt);
  end

  for (genvar g = 0; g < NUM_SERVO; g++) begin : g_lane
    servo_pwm_lane #(.FW(FW)) u_lane (
      .clk           (clk),
      .rst           (rst),
      .load          (wrap),
      .next_w        (next_w[g]),
      .frame_cnt_nxt (frame_cnt_nxt),
      .pwm           (pwm_out[g])
    );
  end
endmodule

// File: tb/tb_servo_motion_sequencer.sv
// Bench for servo_motion_sequencer: command table plus CALC-boundary sequences,
// with a per-frame pulse-width scoreboard fed by a behavioural slew model.
module tb_servo_motion_sequencer;
  localparam int C    = 8;
  localparam int F    = 2500;
  localparam int STEP = 45;
  localparam int CF   = C * F;

  logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [2:0] cmd_servo = '0;
  logic [7:0] cmd_angle = '0;
  logic       cmd_ready, cmd_err, busy, frame_start;
  logic [4:0] pwm_out;

  servo_motion_sequencer #(.CLK_PER_US(C), .FRAME_US(F), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_servo(cmd_servo), .cmd_angle(cmd_angle), .cmd_err(cmd_err),
    .busy(busy), .frame_start(frame_start), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model and width scoreboard
  typedef logic [4:0][11:0] wvec_t;
  wvec_t expq[$];
  int    mtgt[5], mcur[5], hi_cnt[5];
  bit    first_frame;

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      mtgt[i] = 90; mcur[i] = 90; hi_cnt[i] = 0;
    end
    expq.delete();
    expq.push_back({5{12'd1490}});
    first_frame = 1'b1;
  endtask

  task automatic model_step();
    wvec_t wv;
    int d;
    for (int i = 0; i < 5; i++) begin
      d = mtgt[i] - mcur[i];
      if (d > STEP)       mcur[i] = mcur[i] + STEP;
      else if (d < -STEP) mcur[i] = mcur[i] - STEP;
      else                mcur[i] = mtgt[i];
      wv[i] = 12'(mcur[i] * 11 + 500);
    end
    expq.push_back(wv);
  endtask

  // Monitor: counts high samples per frame, checks frame_start and widths
  initial begin
    int    pos;
    wvec_t w;
    forever begin
      @(negedge clk);
      if (cyc == 0) begin
        model_reset();
      end else begin
        pos = cyc % CF;
        for (int i = 0; i < 5; i++)
          hi_cnt[i] = (pos == 0) ? int'(pwm_out[i]) : hi_cnt[i] + int'(pwm_out[i]);
        check("frame_start", frame_start, (pos == 0));
        if (pos == C * (F - 2)) begin
          if (expq.size() == 0) check("width_queue_empty", 1, 0);
          else begin
            w = expq.pop_front();
            for (int i = 0; i < 5; i++)
              check($sformatf("width_clocks_s%0d", i), hi_cnt[i],
                    C * int'(w[i]) - (first_frame ? 1 : 0));
          end
          first_frame = 1'b0;
        end
        if (pos == C * (F - 1) + 5) model_step();
      end
    end
  end

  // Bounded wait until the given cycle, landing at #1 after that edge
  task automatic wait_until(input int t);
    int n = 0;
    while (cyc != t && n < CF + 10) begin
      @(posedge clk); #1; n++;
    end
    if (cyc != t) check("wait_timeout", cyc, t);
  endtask

  task automatic send(input int s, input int a, output int acc);
    int n = 0;
    cmd_valid = 1'b1; cmd_servo = 3'(s); cmd_angle = 8'(a);
    acc = -1;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      n++; @(negedge clk);
    end
    if (!cmd_ready) begin
      check("send_ready_timeout", cmd_ready, 1);
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      acc = cyc;
    end
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    int servo; int angle; bit err; int tgt; bit busy;
  } cmd_t;
  cmd_t tbl[5];

  initial begin
    int acc, lowcnt;
    tbl[0] = '{6, 10, 1'b1, 0, 1'b0};
    tbl[1] = '{2, 30, 1'b0, 30, 1'b1};
    tbl[2] = '{0, 250, 1'b0, 180, 1'b1};
    tbl[3] = '{1, 30, 1'b0, 30, 1'b1};
    tbl[4] = '{1, 150, 1'b0, 150, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm", pwm_out, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_cmd_err", cmd_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", cmd_ready, 1);
    check("pwm_high_frame0", pwm_out, 5'h1f);

    // Command table, all in frame 0
    for (int k = 0; k < 5; k++) begin
      send(tbl[k].servo, tbl[k].angle, acc);
      if (acc < 0) continue;
      if (tbl[k].servo < 5) mtgt[tbl[k].servo] = tbl[k].tgt;
      check("cmd_err_pulse", cmd_err, tbl[k].err);
      @(posedge clk); #1;
      check("cmd_err_clear", cmd_err, 0);
      check("busy_after_cmd", busy, tbl[k].busy);
    end

    // cmd_valid raised while CALC holds off the port at the end of frame 0
    wait_until(C * (F - 1));
    check("ready_low_in_calc", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_servo = 3'd3; cmd_angle = 8'd100;
    lowcnt = 0;
    @(negedge clk);
    while (!cmd_ready && lowcnt < 20) begin
      lowcnt++; @(negedge clk);
    end
    check("ready_low_cycles", lowcnt, 5);
    @(posedge clk); #1;
    check("accept_after_calc", cyc, C * (F - 1) + 6);
    mtgt[3] = 100;
    cmd_valid = 1'b0;

    // Command on the very edge that enters CALC in frame 1 feeds that CALC
    wait_until(CF + C * (F - 1) - 1);
    cmd_valid = 1'b1; cmd_servo = 3'd4; cmd_angle = 8'd120;
    @(negedge clk);
    check("ready_before_calc_entry", cmd_ready, 1);
    @(posedge clk); #1;
    check("ready_drops_on_calc_entry", cmd_ready, 0);
    mtgt[4] = 120;
    cmd_valid = 1'b0;
    wait_until(CF + C * (F - 1) + 5);
    check("busy_during_last_calc", busy, 1);
    @(posedge clk); #1;
    check("busy_settled", busy, 0);

    // One-clock reset while CALC is on servo index 3 in frame 2
    wait_until(2 * CF + C * (F - 1) + 3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midcalc_rst_pwm", pwm_out, 0);
    check("midcalc_rst_ready", cmd_ready, 0);
    check("midcalc_rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_pwm", pwm_out, 5'h1f);
    wait_until(C * 1500);
    for (int i = 0; i < 5; i++)
      check($sformatf("post_rst_width_s%0d", i), hi_cnt[i], C * 1490 - 1);
    check("post_rst_pwm_low", pwm_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #(100000 * 10);
    n_fail++;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/servo_motion_sequencer.md
Name: servo_motion_sequencer

Overview:
- Slew-limited frame sequencer for five hobby servos on the robotic arm.
- Accepts per-servo target angles over a valid/ready command port and ramps each servo's current angle toward its target by at most STEP degrees per PWM frame.
- Time-shares one angle-to-pulse datapath (width_us = angle*11 + 500) across all five servos, then generates the five PWM outputs from a microsecond frame timer.

Parameters:
- CLK_PER_US, 50, clocks per microsecond. Must be >= 8.
- FRAME_US, 20000, PWM frame length in microseconds. Must be > 2480.
- STEP, 2, maximum angle change per servo per frame, in degrees, 1..180.

Ports:
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept; a transfer occurs on a clk edge with cmd_valid & cmd_ready
- cmd_servo  in  3  target servo index, 0..4
- cmd_angle  in  8  target angle in degrees
- cmd_err  out  1  one-cycle pulse: command accepted with cmd_servo >= 5
- busy  out  1  high while any current angle differs from its target
- frame_start  out  1  one-cycle pulse on the clock where frame_cnt wraps to 0
- pwm_out  out  5  bit i = PWM output for servo i

Behaviour:
- Reset (rst sampled high at a clk edge) sets:
  - prescaler = 0, frame_cnt = 0, state = RUN
  - cur[i] = tgt[i] = 90 and active_w[i] = next_w[i] = 1490 for all i
  - pwm_out = 0, cmd_err = 0, frame_start = 0, busy = 0
  - cmd_ready = 0 while rst is high.
- Timing:
  - prescaler counts 0..CLK_PER_US-1; us_tick is asserted when prescaler = CLK_PER_US-1.
  - frame_cnt increments on us_tick and wraps FRAME_US-1 -> 0.
  - On the wrap edge: active_w[i] <= next_w[i] for all i, and frame_start pulses.
- PWM output:
  - pwm_out[i] is registered and equals (frame_cnt < active_w[i]), evaluated on post-update counter values.
  - Pulse width is therefore active_w[i] microseconds, +/- 0 clocks.
- FSM states: RUN, CALC.
  - RUN -> CALC on the us_tick that moves frame_cnt to FRAME_US-1. On that edge calc_idx <= 0.
  - CALC lasts exactly 5 clocks; servo calc_idx is processed on each, with calc_idx incrementing 0..4.
  - After processing index 4, return to RUN.
  - CALC always finishes before the frame wrap, because CLK_PER_US >= 8.
  - The prescaler and frame timer keep running in both states.
- CALC step for servo i:
  - d = tgt[i] - cur[i] (signed).
  - If |d| <= STEP, then cur[i] <= tgt[i]; otherwise cur[i] <= cur[i] +/- STEP. There is no overshoot.
  - next_w[i] <= new_cur*11 + 500, computed in 12 bits. The maximum value is 2480 at 180 degrees, so there is no overflow.
  - There is exactly one shared multiply-add datapath, indexed by calc_idx.
- Command port:
  - cmd_ready = !rst & (state == RUN).
  - On accept with cmd_servo <= 4: tgt[cmd_servo] <= min(cmd_angle, 180).
  - On accept with cmd_servo >= 5: no state changes, and cmd_err pulses on the next cycle.
  - Multiple accepts to the same servo within a frame: the last one wins.
  - A target written in frame N takes effect in the CALC at the end of frame N; its first changed pulse appears in frame N+1.
- busy: registered OR over i of (cur[i] != tgt[i]), updated every clock.
- Reset mid-CALC or mid-pulse: every register returns to its reset value on that edge, and pwm_out is 0 on the following cycle. No partial CALC results are retained.
- Simultaneous events:
  - cmd_valid on the clock that enters CALC: the command is accepted, because the state is still RUN on that edge. The new target is used by that CALC.
  - The frame wrap never coincides with CALC.

Test Plan:
- Reset (CLK_PER_US=10, FRAME_US=4000, STEP=2): after rst release, pwm_out is high for 14900 clocks then low until clock 40000 in every frame; cmd_ready=1, busy=0, frame_start every 40000 clocks.
- Cmd servo 2 angle 95 in frame 0: servo 2 widths in frames 1..4 are 1512, 1534, 1545, 1545 (no overshoot); busy drops after frame 2's CALC; other servos stay at 1490.
- Cmd servo 0 angle 250: target clamps to 180; servo 0 width rises by 22 per frame and settles at 2480 after 45 frames.
- Cmd servo 6 angle 10: handshake completes, cmd_err pulses for 1 cycle, no width changes, busy stays 0.
- cmd_valid held through CALC: cmd_ready is low for exactly 5 clocks, then the command is accepted on the first RUN clock. Two back-to-back commands to servo 1 (angles 30, then 150): only 150 is used.
- Assert rst for 1 clock during CALC index 3: all widths return to 1490, pwm_out=0 next cycle, frame restarts from frame_cnt=0.
